// File: rtl/led_cmd_ctrl_if.sv
// Bus between the uart_rx byte stream and the LED command controller.
// The master side drives received bytes and watches the LED engine;
// the slave side is the controller itself.
interface led_cmd_ctrl_if;
   logic       valid_byte;
   logic [7:0] data_in;
   logic       rx_error;
   logic [7:0] leds;
   logic [1:0] mode;
   logic       frame_done;
   logic       cmd_error;

   modport master (
      output valid_byte, data_in, rx_error,
      input  leds, mode, frame_done, cmd_error
   );

   modport slave (
      input  valid_byte, data_in, rx_error,
      output leds, mode, frame_done, cmd_error
   );
endinterface

// File: rtl/led_cmd_ctrl.sv
// Two-byte command decoder and LED pattern engine (static / bouncing scan / blink).
// A frame is a command byte ('S', 'K' or 'B') followed by one argument byte.
module led_cmd_ctrl #(
   parameter int TICK_DIV    = 12000,
   parameter int BLINK_STEPS = 8,
   parameter int TIMEOUT     = 1200000
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   led_cmd_ctrl_if.slave io_bus
);
   localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TO_W   = $clog2(TIMEOUT);
   // Step counter must hold both step_len-1 (8-bit arg) and BLINK_STEPS-1
   localparam int STEP_W = ($clog2(BLINK_STEPS) > 8) ? $clog2(BLINK_STEPS) : 8;

   localparam logic [7:0] CMD_STATIC = 8'h53;
   localparam logic [7:0] CMD_SCAN   = 8'h4B;
   localparam logic [7:0] CMD_BLINK  = 8'h42;

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_SCAN   = 2'd1;
   localparam logic [1:0] MODE_BLINK  = 2'd2;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT_ARG = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_valid_q;
   logic              w_accept;
   logic              w_is_cmd;
   logic              w_timeout;
   logic              w_latch_cmd;
   logic              w_apply;
   logic              w_frame_done_next;
   logic              w_cmd_error_next;
   logic [7:0]        r_cmd;
   logic [TO_W-1:0]   r_to_cnt;
   logic              r_frame_done;
   logic              r_cmd_error;

   logic [PS_W-1:0]   r_presc;
   logic              w_tick;
   logic [STEP_W-1:0] r_step;
   logic [STEP_W-1:0] w_step_last;
   logic              w_pattern_runs;
   logic              w_step;
   logic [1:0]        r_mode;
   logic [7:0]        r_leds;
   logic [7:0]        r_step_len;
   logic [7:0]        r_blink_pat;
   logic              r_dir;     // 0 = moving left (towards 0x80), 1 = moving right
   logic              r_phase;   // 1 = blink pattern shown
   logic [7:0]        w_scan_next;

   // A byte arrives on the rising edge of valid_byte; data_in is stable then
   assign w_accept  = io_bus.valid_byte & ~r_valid_q;
   assign w_is_cmd  = (io_bus.data_in == CMD_STATIC) || (io_bus.data_in == CMD_SCAN) ||
                      (io_bus.data_in == CMD_BLINK);
   assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

   // Edge detector history; cleared by reset so a held-high byte is taken once after release
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid_q <= 1'b0;
      end else begin
         r_valid_q <= io_bus.valid_byte;
      end
   end

   // Parser state register with the registered status pulses and command latch
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= ST_IDLE;
         r_frame_done <= 1'b0;
         r_cmd_error  <= 1'b0;
         r_cmd        <= 8'h00;
         r_to_cnt     <= '0;
      end else begin
         r_state      <= w_state_next;
         r_frame_done <= w_frame_done_next;
         r_cmd_error  <= w_cmd_error_next;
         if (w_latch_cmd) begin
            r_cmd    <= io_bus.data_in;
            r_to_cnt <= '0;
         end else if (r_state == ST_WAIT_ARG && !w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
      end
   end

   // Parser next-state: abort and argument both return to IDLE, as does timeout
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_is_cmd) begin
               w_state_next = ST_WAIT_ARG;
            end
         end
         ST_WAIT_ARG: begin
            if (io_bus.rx_error || w_accept || w_timeout) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Parser outputs: rx_error beats a simultaneous argument byte, argument beats timeout
   always_comb begin
      w_latch_cmd       = 1'b0;
      w_apply           = 1'b0;
      w_frame_done_next = 1'b0;
      w_cmd_error_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_is_cmd) begin
                  w_latch_cmd = 1'b1;
               end else begin
                  w_cmd_error_next = 1'b1;
               end
            end
         end
         ST_WAIT_ARG: begin
            if (io_bus.rx_error) begin
               w_cmd_error_next = 1'b1;
            end else if (w_accept) begin
               w_apply           = 1'b1;
               w_frame_done_next = 1'b1;
            end else if (w_timeout) begin
               w_cmd_error_next = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign w_tick         = (r_presc == PS_W'(TICK_DIV - 1));
   assign w_pattern_runs = (r_mode == MODE_SCAN) || (r_mode == MODE_BLINK);
   assign w_step_last    = (r_mode == MODE_SCAN) ? (STEP_W'(r_step_len) - STEP_W'(1))
                                                 : STEP_W'(BLINK_STEPS - 1);
   assign w_step         = w_tick && w_pattern_runs && (r_step == w_step_last);
   assign w_scan_next    = r_dir ? (r_leds >> 1) : (r_leds << 1);

   // Pattern tick prescaler; every apply restarts the timebase
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_presc <= '0;
      end else if (w_apply || w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PS_W'(1);
      end
   end

   // Ticks-per-step counter, only meaningful while a moving pattern runs
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_step <= '0;
      end else if (w_apply) begin
         r_step <= '0;
      end else if (w_tick && w_pattern_runs) begin
         r_step <= (r_step == w_step_last) ? '0 : (r_step + STEP_W'(1));
      end
   end

   // LED engine: frame apply loads a new pattern, otherwise advance on each step
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_mode      <= MODE_STATIC;
         r_leds      <= 8'h00;
         r_step_len  <= 8'd1;
         r_blink_pat <= 8'h00;
         r_dir       <= 1'b0;
         r_phase     <= 1'b1;
      end else if (w_apply) begin
         case (r_cmd)
            CMD_STATIC: begin
               r_mode <= MODE_STATIC;
               r_leds <= io_bus.data_in;
            end
            CMD_SCAN: begin
               r_mode     <= MODE_SCAN;
               r_step_len <= (io_bus.data_in == 8'h00) ? 8'd1 : io_bus.data_in;
               r_leds     <= 8'h01;
               r_dir      <= 1'b0;
            end
            CMD_BLINK: begin
               r_mode      <= MODE_BLINK;
               r_blink_pat <= io_bus.data_in;
               r_phase     <= 1'b1;
               r_leds      <= io_bus.data_in;
            end
            default: ;
         endcase
      end else if (w_step) begin
         if (r_mode == MODE_SCAN) begin
            r_leds <= w_scan_next;
            // Turn around at the ends so neither endpoint is shown twice
            if (!r_dir && w_scan_next == 8'h80) begin
               r_dir <= 1'b1;
            end else if (r_dir && w_scan_next == 8'h01) begin
               r_dir <= 1'b0;
            end
         end else begin
            r_phase <= ~r_phase;
            r_leds  <= r_phase ? 8'h00 : r_blink_pat;
         end
      end
   end

   assign io_bus.leds       = r_leds;
   assign io_bus.mode       = r_mode;
   assign io_bus.frame_done = r_frame_done;
   assign io_bus.cmd_error  = r_cmd_error;
endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Randomized bench for led_cmd_ctrl with a cycle-level behavioural model:
// the model tracks "time since apply" and derives the LED value arithmetically.
module tb_led_cmd_ctrl;
   localparam int TICK_DIV    = 4;
   localparam int BLINK_STEPS = 2;
   localparam int TIMEOUT     = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   led_cmd_ctrl_if bus_if ();

   led_cmd_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .BLINK_STEPS(BLINK_STEPS),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .io_bus   (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int cnt_fd = 0;
   int cnt_ce = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_vq    = 1'b0;
   bit         m_wait  = 1'b0;
   logic [7:0] m_cmd   = 8'h00;
   int         m_wcnt  = 0;
   logic [1:0] m_mode  = 2'd0;
   logic [7:0] m_static = 8'h00;
   logic [7:0] m_pat   = 8'h00;
   int         m_len   = 1;
   int         m_t     = 0;
   logic [7:0] e_leds  = 8'h00;
   bit         e_fd    = 1'b0;
   bit         e_ce    = 1'b0;
   bit         m_acc;
   bit         m_applied;
   logic [7:0] m_d;

   function automatic logic [7:0] model_leds();
      int n;
      int idx;
      logic [7:0] one;
      one = 8'h01;
      case (m_mode)
         2'd1: begin
            n   = m_t / (m_len * TICK_DIV);
            idx = n % 14;
            return (idx < 8) ? (one << idx) : (one << (14 - idx));
         end
         2'd2: begin
            n = m_t / (BLINK_STEPS * TICK_DIV);
            return (n % 2 == 0) ? m_pat : 8'h00;
         end
         default: return m_static;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_vq = 0; m_wait = 0; m_mode = 0; m_static = 0; m_pat = 0;
            m_len = 1; m_t = 0; e_fd = 0; e_ce = 0;
         end else begin
            m_d   = bus_if.data_in;
            m_acc = bus_if.valid_byte && !m_vq;
            m_vq  = bus_if.valid_byte;
            e_fd = 0; e_ce = 0; m_applied = 0;
            if (m_wait) begin
               if (bus_if.rx_error) begin
                  e_ce = 1; m_wait = 0;
               end else if (m_acc) begin
                  e_fd = 1; m_wait = 0; m_applied = 1;
                  if (m_cmd == 8'h53) begin m_mode = 0; m_static = m_d; end
                  else if (m_cmd == 8'h4B) begin m_mode = 1; m_len = (m_d == 0) ? 1 : int'(m_d); end
                  else begin m_mode = 2; m_pat = m_d; end
               end else begin
                  m_wcnt++;
                  if (m_wcnt == TIMEOUT) begin e_ce = 1; m_wait = 0; end
               end
            end else if (m_acc) begin
               if (m_d == 8'h53 || m_d == 8'h4B || m_d == 8'h42) begin
                  m_wait = 1; m_cmd = m_d; m_wcnt = 0;
               end else begin
                  e_ce = 1;
               end
            end
            if (m_applied) m_t = 0; else m_t++;
         end
         e_leds = model_leds();
      end
   end

   // Per-cycle compare of every output against the model, plus pulse counters
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("leds",       bus_if.leds,       e_leds);
            check("mode",       bus_if.mode,       m_mode);
            check("frame_done", bus_if.frame_done, e_fd);
            check("cmd_error",  bus_if.cmd_error,  e_ce);
            if (bus_if.frame_done && bus_if.cmd_error) check("pulse_overlap", 1, 0);
         end
         if (bus_if.frame_done) cnt_fd++;
         if (bus_if.cmd_error)  cnt_ce++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Send one byte; returns one cycle after the accept edge with pulses seen right after it
   task automatic put(input logic [7:0] b, output logic fd, output logic ce);
      bus_if.valid_byte = 1'b1;
      bus_if.data_in    = b;
      @(posedge clk);
      #2;
      fd = bus_if.frame_done;
      ce = bus_if.cmd_error;
      bus_if.valid_byte = 1'b0;
      @(posedge clk);
      #2;
   endtask

   logic [7:0] seq [0:16];
   logic       fd, ce;
   int         c0, c1, n80, n01;

   initial begin
      seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
      bus_if.valid_byte = 1'b0;
      bus_if.data_in    = 8'h00;
      bus_if.rx_error   = 1'b0;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      tick(3);
      check("reset_leds", bus_if.leds, 8'h00);
      check("reset_mode", bus_if.mode, 2'd0);
      check("reset_fd",   bus_if.frame_done, 1'b0);
      check("reset_ce",   bus_if.cmd_error, 1'b0);
      rst_n = 1'b1;
      tick(2);

      // Static
      put(8'h53, fd, ce);
      put(8'hA5, fd, ce);
      check("static_fd", fd, 1'b1);
      check("static_ce", ce, 1'b0);
      check("static_leds", bus_if.leds, 8'hA5);
      check("static_mode", bus_if.mode, 2'd0);

      // Scan, one tick per step: 4 cycles per step
      put(8'h4B, fd, ce);
      put(8'h01, fd, ce);
      check("scan_start", bus_if.leds, 8'h01);
      check("scan_mode", bus_if.mode, 2'd1);
      n80 = 0; n01 = 0;
      for (int i = 1; i <= 16; i++) begin
         tick((i == 1) ? 3 : 4);
         check($sformatf("scan_step%0d", i), bus_if.leds, seq[i]);
         if (i <= 14 && bus_if.leds == 8'h80) n80++;
         if (i <= 14 && bus_if.leds == 8'h01) n01++;
      end
      check("scan_80_once", n80, 1);
      check("scan_01_once", n01, 1);

      // Blink: 8 cycles per phase
      put(8'h42, fd, ce);
      put(8'h3C, fd, ce);
      check("blink_on0", bus_if.leds, 8'h3C);
      tick(7);
      check("blink_off1", bus_if.leds, 8'h00);
      tick(8);
      check("blink_on2", bus_if.leds, 8'h3C);
      tick(8);
      check("blink_off3", bus_if.leds, 8'h00);
      put(8'h42, fd, ce);
      put(8'h00, fd, ce);
      check("blink0_a", bus_if.leds, 8'h00);
      tick(8);
      check("blink0_b", bus_if.leds, 8'h00);
      tick(8);
      check("blink0_c", bus_if.leds, 8'h00);

      // Errors
      put(8'h53, fd, ce);
      put(8'h5A, fd, ce);
      put(8'h7A, fd, ce);
      check("unknown_ce", ce, 1'b1);
      check("unknown_fd", fd, 1'b0);
      check("unknown_leds", bus_if.leds, 8'h5A);
      c0 = cnt_ce;
      put(8'h53, fd, ce);
      tick(50);
      check("timeout_count", cnt_ce - c0, 1);
      put(8'hFF, fd, ce);
      check("after_to_ce", ce, 1'b1);
      check("after_to_leds", bus_if.leds, 8'h5A);

      // Abort on the argument edge, then a 20-cycle held byte
      put(8'h53, fd, ce);
      c0 = cnt_ce;
      bus_if.valid_byte = 1'b1;
      bus_if.data_in    = 8'h11;
      bus_if.rx_error   = 1'b1;
      tick(1);
      check("abort_ce", bus_if.cmd_error, 1'b1);
      check("abort_fd", bus_if.frame_done, 1'b0);
      bus_if.rx_error = 1'b0;
      tick(19);
      bus_if.valid_byte = 1'b0;
      tick(2);
      check("abort_ce_count", cnt_ce - c0, 1);
      check("abort_leds", bus_if.leds, 8'h5A);
      c1 = cnt_fd;
      bus_if.valid_byte = 1'b1;
      bus_if.data_in    = 8'h53;
      tick(20);
      bus_if.valid_byte = 1'b0;
      tick(1);
      put(8'h33, fd, ce);
      check("held_fd", fd, 1'b1);
      check("held_leds", bus_if.leds, 8'h33);
      tick(1);
      check("held_fd_count", cnt_fd - c1, 1);

      // Reset mid-scan, reset in WAIT_ARG, reset while valid_byte is high
      put(8'h4B, fd, ce);
      put(8'h02, fd, ce);
      tick(10);
      rst_n = 1'b0;
      #1;
      check("rst_scan_leds", bus_if.leds, 8'h00);
      check("rst_scan_mode", bus_if.mode, 2'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      put(8'h53, fd, ce);
      rst_n = 1'b0;
      #1;
      check("rst_wait_leds", bus_if.leds, 8'h00);
      check("rst_wait_fd", bus_if.frame_done, 1'b0);
      tick(1);
      bus_if.valid_byte = 1'b1;
      bus_if.data_in    = 8'h53;
      tick(1);
      rst_n = 1'b1;
      tick(3);
      bus_if.valid_byte = 1'b0;
      tick(1);
      put(8'h0F, fd, ce);
      check("post_rst_fd", fd, 1'b1);
      check("post_rst_leds", bus_if.leds, 8'h0F);

      // Randomized traffic, checked every cycle by the model
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 99);
         if (r < 20)      b = 8'h53;
         else if (r < 40) b = 8'h4B;
         else if (r < 60) b = 8'h42;
         else if (r < 75) b = 8'($urandom);
         else             b = 8'($urandom_range(0, 3));
         bus_if.valid_byte = 1'b1;
         bus_if.data_in    = b;
         bus_if.rx_error   = ($urandom_range(0, 99) < 8);
         tick(1);
         bus_if.rx_error = 1'b0;
         tick($urandom_range(0, 2));
         bus_if.valid_byte = 1'b0;
         if ($urandom_range(0, 99) < 5) bus_if.rx_error = 1'b1;
         tick(1);
         bus_if.rx_error = 1'b0;
         if ($urandom_range(0, 99) < 4) tick(60);
         else tick($urandom_range(0, 8));
      end
      tick(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
